// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: sequences the fetch PC, issues credit-limited imem requests,
// buffers responses in a FIFO for decode and flushes on redirect by killing in-flight responses.

module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] kill_q, kill_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [SUM_W-1:0] out_sum;
    logic [SUM_W-1:0] credit_sum;

    logic [31:0] data_mem [FIFO_DEPTH];
    logic [31:0] pc_mem   [FIFO_DEPTH];

    logic        req_fire;
    logic        rsp_take;
    logic        rsp_drop;
    logic        push;
    logic        pop;
    logic [31:0] redirect_target;
    logic        unused_redirect_lsb;

    assign redirect_target     = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // A response with nothing outstanding is a protocol error and is ignored outright.
    always_comb begin
        req_fire = imem_req_valid && imem_req_ready;
        rsp_take = imem_rsp_valid && (outstanding_q != '0);
        rsp_drop = rsp_take && (kill_q != '0);
        push     = rsp_take && !rsp_drop && !redirect_valid;
        pop      = inst_valid && inst_ready && !redirect_valid;
    end

    always_comb begin
        out_sum = {1'b0, outstanding_q} + SUM_W'(req_fire) - SUM_W'(rsp_take);
        if (out_sum > {1'b0, DEPTH_C}) begin
            outstanding_d = DEPTH_C;
        end else begin
            outstanding_d = out_sum[CNT_W-1:0];
        end
    end

    // On redirect every response still owed to the old stream must be dropped.
    always_comb begin
        kill_d = kill_q;
        if (redirect_valid) begin
            kill_d = outstanding_d;
        end else if (rsp_drop) begin
            kill_d = kill_q - ONE_C;
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            rsp_pc_d   = redirect_target;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
            end
        end
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect_valid) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + ONE_C;
            end else if (pop && !push) begin
                count_d = count_q - ONE_C;
            end
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            kill_q        <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Storage needs no reset: entries are only observed while count_q covers them.
    always_ff @(posedge cpu_clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= imem_rsp_data;
            pc_mem[wr_ptr_q]   <= rsp_pc_q;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:         state_d = StRun;
            StRun, StDrain: state_d = (kill_d != '0) ? StDrain : StRun;
            default:        state_d = StBoot;
        endcase
    end

    // Credit covers both buffered and in-flight words, so responses can never overflow.
    always_comb begin
        credit_sum     = {1'b0, count_q} + {1'b0, outstanding_q};
        imem_req_valid = (state_q != StBoot) && (credit_sum < {1'b0, DEPTH_C});
        imem_req_addr  = fetch_pc_q;
        inst_valid     = (count_q != '0);
        inst           = NOP_INST;
        inst_pc        = rsp_pc_q;
        if (inst_valid) begin
            inst    = data_mem[rd_ptr_q];
            inst_pc = pc_mem[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with an in-order, fixed-latency instruction memory model.

module tb_inst_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        cpu_clk;
    logic        cpu_rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int          n_checks;
    int          n_fail;
    int unsigned mem_lat;
    logic [31:0] dlog_pc[$];
    logic [31:0] dlog_data[$];
    logic [31:0] rlog[$];

    inst_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(4),
        .NOP_INST  (NOP)
    ) dut (
        .cpu_clk       (cpu_clk),
        .cpu_rst       (cpu_rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0010_0093;
            32'h4:   return 32'h0020_0113;
            32'h8:   return 32'h0030_0193;
            32'hC:   return 32'h4000_0233;
            32'h10:  return 32'h0050_0293;
            default: return {a[29:0], 2'b11};
        endcase
    endfunction

    // Memory decides at mid-cycle what the next edge accepts, then drives its response after it.
    initial begin : imem_model
        logic [31:0] pend_addr[$];
        int unsigned pend_due[$];
        int unsigned ecnt;
        logic        nv;
        logic [31:0] nd;
        ecnt = 0;
        nv = 1'b0;
        nd = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        forever begin
            @(negedge cpu_clk);
            if (!cpu_rst) begin
                pend_addr.delete();
                pend_due.delete();
                ecnt = 0;
                nv = 1'b0;
            end else begin
                ecnt++;
                if (imem_req_valid && imem_req_ready) begin
                    pend_addr.push_back(imem_req_addr);
                    pend_due.push_back(ecnt + mem_lat - 1);
                end
                nv = 1'b0;
                if (pend_addr.size() != 0 && pend_due[0] <= ecnt) begin
                    nv = 1'b1;
                    nd = mem_word(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end
            end
            @(posedge cpu_clk);
            #1;
            imem_rsp_valid = nv;
            imem_rsp_data = nd;
        end
    end

    initial begin : monitor
        forever begin
            @(negedge cpu_clk);
            if (cpu_rst) begin
                if (redirect_valid) begin
                    dlog_pc.delete();
                    dlog_data.delete();
                end else if (inst_valid && inst_ready) begin
                    dlog_pc.push_back(inst_pc);
                    dlog_data.push_back(inst);
                end
                if (imem_req_valid && imem_req_ready) rlog.push_back(imem_req_addr);
            end
        end
    end

    task automatic tick();
        @(posedge cpu_clk);
        #2;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset(input logic ir, input logic rr, input int unsigned lat);
        cpu_rst = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_ready = ir;
        imem_req_ready = rr;
        mem_lat = lat;
        ticks(2);
        dlog_pc.delete();
        dlog_data.delete();
        rlog.delete();
        cpu_rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc [5];
        logic [31:0] exp_data [5];
        exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        exp_data = '{32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'h4000_0233, 32'h0050_0293};
        cpu_rst = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b1;
        imem_req_ready = 1'b1;
        mem_lat = 1;
        ticks(2);
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        n_checks++; if (imem_req_addr !== 32'h0) begin n_fail++;
            $display("FAIL reset_req_addr: got %h want 00000000", imem_req_addr); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
        n_checks++; if (inst !== NOP) begin n_fail++;
            $display("FAIL reset_inst: got %h want %h", inst, NOP); end
        n_checks++; if (inst_pc !== 32'h0) begin n_fail++;
            $display("FAIL reset_inst_pc: got %h want 00000000", inst_pc); end
        dlog_pc.delete();
        dlog_data.delete();
        rlog.delete();
        cpu_rst = 1'b1;
        #1;
        n_checks++; if (imem_req_valid !== 1'b0 || dut.state_q !== 2'd0) begin n_fail++;
            $display("FAIL boot_no_req: req_valid %b state %0d want 0 and 0",
                     imem_req_valid, dut.state_q); end
        tick();
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++;
            $display("FAIL boot_first_req: valid %b addr %h want 1 00000000",
                     imem_req_valid, imem_req_addr); end
        ticks(10);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (i >= rlog.size() || rlog[i] !== exp_pc[i]) begin n_fail++;
                $display("FAIL boot_req_addr[%0d]: got %h want %h", i,
                         (i < rlog.size()) ? rlog[i] : 32'hx, exp_pc[i]); end
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= dlog_pc.size() || dlog_pc[i] !== exp_pc[i] || dlog_data[i] !== exp_data[i])
            begin n_fail++;
                $display("FAIL boot_deliver[%0d]: got pc %h inst %h want pc %h inst %h", i,
                         (i < dlog_pc.size()) ? dlog_pc[i] : 32'hx,
                         (i < dlog_data.size()) ? dlog_data[i] : 32'hx, exp_pc[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0, 1'b1, 1);
        ticks(11);
        n_checks++; if (rlog.size() != 4) begin n_fail++;
            $display("FAIL bp_req_count: got %0d want 4", rlog.size()); end
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++;
            $display("FAIL bp_req_stall: got %b want 0", imem_req_valid); end
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== 32'h0010_0093)
        begin n_fail++;
            $display("FAIL bp_head: valid %b pc %h inst %h want 1 00000000 00100093",
                     inst_valid, inst_pc, inst); end
        inst_ready = 1'b1;
        ticks(3);
        inst_ready = 1'b0;
        ticks(10);
        n_checks++; if (rlog.size() != 7 || rlog[rlog.size()-1] !== 32'h18) begin n_fail++;
            $display("FAIL bp_refill: got %0d reqs want 7 ending at 00000018", rlog.size()); end
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++;
            $display("FAIL bp_restall: got %b want 0", imem_req_valid); end
        n_checks++; if (dlog_pc.size() != 3 || inst_pc !== 32'hC || inst !== 32'h4000_0233)
        begin n_fail++;
            $display("FAIL bp_after_pops: pops %0d head pc %h inst %h want 3 0000000c 40000233",
                     dlog_pc.size(), inst_pc, inst); end
    endtask

    task automatic test_redirect_drain();
        do_reset(1'b1, 1'b0, 3);
        tick();
        imem_req_ready = 1'b1;
        ticks(2);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        n_checks++; if (dut.state_q !== 2'd2 || dut.kill_q !== 3'd2) begin n_fail++;
            $display("FAIL drain_enter: state %0d kill %0d want 2 2", dut.state_q, dut.kill_q); end
        n_checks++; if (imem_req_addr !== 32'h100 || imem_req_valid !== 1'b1) begin n_fail++;
            $display("FAIL drain_new_req: addr %h valid %b want 00000100 1",
                     imem_req_addr, imem_req_valid); end
        tick();
        n_checks++; if (dut.state_q !== 2'd2 || dut.kill_q !== 3'd1) begin n_fail++;
            $display("FAIL drain_mid: state %0d kill %0d want 2 1", dut.state_q, dut.kill_q); end
        tick();
        n_checks++; if (dut.state_q !== 2'd1 || dut.kill_q !== 3'd0) begin n_fail++;
            $display("FAIL drain_exit: state %0d kill %0d want 1 0", dut.state_q, dut.kill_q); end
        ticks(12);
        n_checks++;
        if (dlog_pc.size() < 2 || dlog_pc[0] !== 32'h100 || dlog_data[0] !== 32'h403 ||
            dlog_pc[1] !== 32'h104) begin n_fail++;
            $display("FAIL drain_deliver: n %0d pc0 %h inst0 %h want pc0 00000100 inst0 00000403",
                     dlog_pc.size(), (dlog_pc.size() > 0) ? dlog_pc[0] : 32'hx,
                     (dlog_data.size() > 0) ? dlog_data[0] : 32'hx); end
    endtask

    task automatic test_simultaneous();
        do_reset(1'b1, 1'b1, 1);
        ticks(5);
        n_checks++;
        if (imem_req_valid !== 1'b1 || inst_valid !== 1'b1 || dut.outstanding_q !== 3'd1)
        begin n_fail++;
            $display("FAIL sim_precond: req %b inst_valid %b outstanding %0d want 1 1 1",
                     imem_req_valid, inst_valid, dut.outstanding_q); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (inst_valid !== 1'b0 || inst !== NOP) begin n_fail++;
            $display("FAIL sim_flush: valid %b inst %h want 0 %h", inst_valid, inst, NOP); end
        n_checks++; if (dut.kill_q !== 3'd1 || dut.state_q !== 2'd2) begin n_fail++;
            $display("FAIL sim_kill: kill %0d state %0d want 1 2", dut.kill_q, dut.state_q); end
        n_checks++; if (imem_req_addr !== 32'h200) begin n_fail++;
            $display("FAIL sim_req_addr: got %h want 00000200", imem_req_addr); end
        tick();
        n_checks++; if (inst_valid !== 1'b0 || dut.state_q !== 2'd1) begin n_fail++;
            $display("FAIL sim_drop: valid %b state %0d want 0 1", inst_valid, dut.state_q); end
        tick();
        n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst !== 32'h803)
        begin n_fail++;
            $display("FAIL sim_first: valid %b pc %h inst %h want 1 00000200 00000803",
                     inst_valid, inst_pc, inst); end
        ticks(4);
        n_checks++;
        if (dlog_pc.size() < 2 || dlog_pc[0] !== 32'h200 || dlog_pc[1] !== 32'h204) begin
            n_fail++;
            $display("FAIL sim_stream: n %0d pc0 %h want pc0 00000200 pc1 00000204",
                     dlog_pc.size(), (dlog_pc.size() > 0) ? dlog_pc[0] : 32'hx); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        do_reset(1'b1, 1'b1, 1);
        ticks(5);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        ticks(8);
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (i >= dlog_pc.size() || dlog_pc[i] !== exp_pc[i]) begin n_fail++;
                $display("FAIL wrap_pc[%0d]: got %h want %h", i,
                         (i < dlog_pc.size()) ? dlog_pc[i] : 32'hx, exp_pc[i]); end
        end
        n_checks++; if (dlog_pc.size() < 3 || dlog_data[2] !== 32'h0010_0093) begin n_fail++;
            $display("FAIL wrap_data: got %h want 00100093",
                     (dlog_data.size() > 2) ? dlog_data[2] : 32'hx); end
    endtask

    task automatic test_async_reset();
        do_reset(1'b1, 1'b1, 1);
        ticks(6);
        n_checks++; if (inst_valid !== 1'b1 || imem_req_valid !== 1'b1) begin n_fail++;
            $display("FAIL arst_precond: inst_valid %b req_valid %b want 1 1",
                     inst_valid, imem_req_valid); end
        #1;
        cpu_rst = 1'b0;
        #1;
        n_checks++; if (inst_valid !== 1'b0 || inst !== NOP) begin n_fail++;
            $display("FAIL arst_inst: valid %b inst %h want 0 %h", inst_valid, inst, NOP); end
        n_checks++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0) begin n_fail++;
            $display("FAIL arst_req: valid %b addr %h want 0 00000000",
                     imem_req_valid, imem_req_addr); end
        tick();
        cpu_rst = 1'b1;
        tick();
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++;
            $display("FAIL arst_restart: valid %b addr %h want 1 00000000",
                     imem_req_valid, imem_req_addr); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        cpu_rst = 1'b0;
        inst_ready = 1'b0;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        mem_lat = 1;
        test_reset();
        test_backpressure();
        test_redirect_drain();
        test_simultaneous();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
